// File: rtl/timer_gen_pkg.sv
// timer_pkg: shared state encoding and mode constants for the countdown timer
package timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic TIMER_ONESHOT = 1'b0;
    localparam logic TIMER_RELOAD  = 1'b1;
endpackage

// File: rtl/timer_gen_if.sv
// timer_gen_if: load/control inputs and status outputs of the countdown timer
interface timer_gen_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  enable;
    logic                  valid;
    logic [WIDTH-1:0]      value;
    logic                  mode;
    logic [PRESCALE_W-1:0] prescale;
    logic                  trigger;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    modport master (output enable, valid, value, mode, prescale, input trigger, count, busy);
    modport slave  (input enable, valid, value, mode, prescale, output trigger, count, busy);
endinterface

// File: rtl/timer_gen_prescaler.sv
// timer_prescaler: emits tick once every ps_q+1 enabled cycles; clear restarts the phase
module timer_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] ps_q,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] pcnt;

    assign tick = enable && (pcnt == ps_q);

    always_ff @(posedge clk) begin
        if (reset || clear)
            pcnt <= '0;
        else if (enable)
            pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
    end
endmodule

// File: rtl/timer_gen.sv
// timer_gen: prescaled WIDTH-bit down-counter with one-shot/auto-reload expiry pulse
module timer_gen
    import timer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input logic        clk,
    input logic        reset,
    timer_gen_if.slave bus
);
    state_t                state, state_n;
    logic [WIDTH-1:0]      cnt, cnt_n, reload;
    logic                  mode_q, trigger_q, trigger_n;
    logic [PRESCALE_W-1:0] ps_q;
    logic                  tick, last;

    timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_ps (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.valid),
        .enable (state == RUN && bus.enable),
        .ps_q   (ps_q),
        .tick   (tick)
    );

    // expiry is detected at 1 so cnt never wraps; a load overrides a coincident tick
    assign last = cnt == WIDTH'(1);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        trigger_n = 1'b0;
        state_n   = bus.valid ? (bus.value != '0 ? RUN : IDLE) :
                    (tick && last && mode_q == TIMER_ONESHOT) ? DONE : state;
        cnt_n     = bus.valid ? bus.value : !tick ? cnt : !last ? cnt - WIDTH'(1) :
                    mode_q == TIMER_RELOAD ? reload : '0;
        trigger_n = !bus.valid && tick && last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            reload    <= '0;
            mode_q    <= TIMER_ONESHOT;
            ps_q      <= '0;
            trigger_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            trigger_q <= trigger_n;
            if (bus.valid) begin
                reload <= bus.value;
                mode_q <= bus.mode;
                ps_q   <= bus.prescale;
            end
        end
    end

    assign bus.trigger = trigger_q;
    assign bus.count   = cnt;
    assign bus.busy    = state == RUN;
endmodule
